lpif_rx_frame_detector: RTL and testbench

- Receive-side framing stage directly upstream of LPIF_RX_Control_DataFlow.
- Scans the descrambled, lane-merged Gen1/Gen2 byte stream (64 bytes/cycle) for K-code framing symbols: STP K27.7 = 0xFB, SDP K28.2 = 0x5C, END K29.7 = 0xFD, EDB K30.7 = 0xFE.
- Produces the per-byte tlpstart/dllpstart/tlpend/dllpend/edb/packetValid vectors and the registered packetData bus that the LPIF stage consumes.
- Tracks packet context across cycle boundaries and flags framing errors.

---
 rtl/pcie_rx_pkg.sv | 28 ++
 rtl/frame_symbol_decode.sv | 28 ++
 rtl/lpif_rx_frame_detector.sv | 161 ++++++++++++++++
 tb/tb_lpif_rx_frame_detector.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pcie_rx_pkg.sv
// Shared definitions for the PCIe Gen1/Gen2 receive framing path:
// K-code values, packet context states and per-byte symbol classes.
package pcie_rx_pkg;

    localparam int DEFAULT_BYTES = 64;

    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;

    typedef enum logic [1:0] {
        CTX_IDLE,
        CTX_TLP,
        CTX_DLLP
    } ctx_e;

    typedef enum logic [2:0] {
        SYM_NONE,
        SYM_DATA,
        SYM_STP,
        SYM_SDP,
        SYM_END,
        SYM_EDB,
        SYM_OTHER_K
    } sym_class_e;

endpackage

// File: rtl/frame_symbol_decode.sv
// Classifies one received byte into a framing symbol class; purely
// combinational, instantiated once per byte lane by the frame detector.
module frame_symbol_decode
    import pcie_rx_pkg::*;
(
    input  logic       kchar_i,
    input  logic       valid_i,
    input  logic [7:0] byte_i,
    output sym_class_e sym_o
);

    always_comb begin
        if (!valid_i) begin
            sym_o = SYM_NONE;
        end else if (!kchar_i) begin
            sym_o = SYM_DATA;
        end else begin
            case (byte_i)
                K_STP:   sym_o = SYM_STP;
                K_SDP:   sym_o = SYM_SDP;
                K_END:   sym_o = SYM_END;
                K_EDB:   sym_o = SYM_EDB;
                default: sym_o = SYM_OTHER_K;
            endcase
        end
    end

endmodule

// File: rtl/lpif_rx_frame_detector.sv
// Receive framing stage: scans each beat MSB-byte first for STP/SDP/END/EDB,
// emits registered per-byte markers. Define FRAME_ERR_CNT_EN to add frame_err_cnt.
module lpif_rx_frame_detector
    import pcie_rx_pkg::*;
#(
    parameter int BYTES    = DEFAULT_BYTES,
    parameter int DLLP_LEN = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8*BYTES-1:0] rx_data,
    input  logic [BYTES-1:0]   rx_kchar,
    input  logic [BYTES-1:0]   rx_byte_valid,
    input  logic [2:0]         gen,
    input  logic               link_up,
    output logic [8*BYTES-1:0] packetData,
    output logic [BYTES-1:0]   tlpstart,
    output logic [BYTES-1:0]   dllpstart,
    output logic [BYTES-1:0]   tlpend,
    output logic [BYTES-1:0]   dllpend,
    output logic [BYTES-1:0]   edb,
    output logic [BYTES-1:0]   packetValid,
    output logic               framing_error
`ifdef FRAME_ERR_CNT_EN
    ,
    output logic [15:0]        frame_err_cnt
`endif
);

    localparam int CW = $clog2(DLLP_LEN + 2);

    sym_class_e     sym [BYTES];
    ctx_e           ctx_q, ctx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BYTES-1:0] tlps_d, dllps_d, tlpe_d, dllpe_d, edb_d, pv_d;
    logic           err_d;

    for (genvar g = 0; g < BYTES; g++) begin : g_dec
        frame_symbol_decode u_dec (
            .kchar_i (rx_kchar[g]),
            .valid_i (rx_byte_valid[g]),
            .byte_i  (rx_data[8*g +: 8]),
            .sym_o   (sym[g])
        );
    end

    always_comb begin
        // NOTE: every variable gets a default before the scan so no path leaves it unassigned (no latch).
        ctx_d   = ctx_q;
        cnt_d   = cnt_q;
        tlps_d  = '0;
        dllps_d = '0;
        tlpe_d  = '0;
        dllpe_d = '0;
        edb_d   = '0;
        pv_d    = '0;
        err_d   = 1'b0;

        for (int i = BYTES - 1; i >= 0; i--) begin
            case (sym[i])
                SYM_STP: begin
                    // A start inside an open packet aborts it and opens a new one.
                    if (ctx_d != CTX_IDLE) err_d = 1'b1;
                    tlps_d[i] = 1'b1;
                    ctx_d     = CTX_TLP;
                end
                SYM_SDP: begin
                    if (ctx_d != CTX_IDLE) err_d = 1'b1;
                    dllps_d[i] = 1'b1;
                    ctx_d      = CTX_DLLP;
                    cnt_d      = '0;
                end
                SYM_DATA: begin
                    if (ctx_d == CTX_TLP) begin
                        pv_d[i] = 1'b1;
                    end else if (ctx_d == CTX_DLLP) begin
                        pv_d[i] = 1'b1;
                        if (cnt_d == CW'(DLLP_LEN)) begin
                            cnt_d = CW'(DLLP_LEN + 1);
                            err_d = 1'b1;
                            ctx_d = CTX_IDLE;
                        end else begin
                            cnt_d = cnt_d + CW'(1);
                        end
                    end
                end
                SYM_END: begin
                    case (ctx_d)
                        CTX_TLP:  tlpe_d[i] = 1'b1;
                        CTX_DLLP: begin
                            dllpe_d[i] = 1'b1;
                            if (cnt_d != CW'(DLLP_LEN)) err_d = 1'b1;
                        end
                        default:  err_d = 1'b1;
                    endcase
                    ctx_d = CTX_IDLE;
                end
                SYM_EDB: begin
                    if (ctx_d == CTX_TLP) edb_d[i] = 1'b1;
                    else                  err_d    = 1'b1;
                    ctx_d = CTX_IDLE;
                end
                SYM_OTHER_K: begin
                    if (ctx_d != CTX_IDLE) err_d = 1'b1;
                    ctx_d = CTX_IDLE;
                end
                default: ;
            endcase
        end

        if (gen >= 3'd3) begin
            ctx_d   = CTX_IDLE;
            cnt_d   = '0;
            tlps_d  = '0;
            dllps_d = '0;
            tlpe_d  = '0;
            dllpe_d = '0;
            edb_d   = '0;
            pv_d    = rx_byte_valid;
            err_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset || !link_up) begin
            ctx_q         <= CTX_IDLE;
            cnt_q         <= '0;
            packetData    <= '0;
            tlpstart      <= '0;
            dllpstart     <= '0;
            tlpend        <= '0;
            dllpend       <= '0;
            edb           <= '0;
            packetValid   <= '0;
            framing_error <= 1'b0;
        end else begin
            ctx_q         <= ctx_d;
            cnt_q         <= cnt_d;
            packetData    <= rx_data;
            tlpstart      <= tlps_d;
            dllpstart     <= dllps_d;
            tlpend        <= tlpe_d;
            dllpend       <= dllpe_d;
            edb           <= edb_d;
            packetValid   <= pv_d;
            framing_error <= err_d;
        end
    end

`ifdef FRAME_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_cnt <= '0;
        end else if (link_up && err_d && frame_err_cnt != 16'hFFFF) begin
            frame_err_cnt <= frame_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lpif_rx_frame_detector.sv
// Directed scoreboard bench for lpif_rx_frame_detector (64-byte beats);
// also checks frame_err_cnt when FRAME_ERR_CNT_EN is defined.
module tb_lpif_rx_frame_detector;

    localparam int B = 64;
    localparam logic [B-1:0] Z   = '0;
    localparam logic [B-1:0] B63 = 64'h8000_0000_0000_0000;

    logic           clk = 1'b0;
    logic           reset;
    logic           link_up;
    logic [2:0]     gen;
    logic [8*B-1:0] rx_data;
    logic [B-1:0]   rx_kchar;
    logic [B-1:0]   rx_byte_valid;
    logic [8*B-1:0] packetData;
    logic [B-1:0]   tlpstart, dllpstart, tlpend, dllpend, edb, packetValid;
    logic           framing_error;
`ifdef FRAME_ERR_CNT_EN
    logic [15:0]    frame_err_cnt;
    int             exp_cnt = 0;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [8*B-1:0] data;
        logic [B-1:0]   ts, ds, te, de, eb, pv;
        logic           err;
        logic           rst;
    } exp_t;

    exp_t sb[$];

    lpif_rx_frame_detector dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_kchar      (rx_kchar),
        .rx_byte_valid (rx_byte_valid),
        .gen           (gen),
        .link_up       (link_up),
        .packetData    (packetData),
        .tlpstart      (tlpstart),
        .dllpstart     (dllpstart),
        .tlpend        (tlpend),
        .dllpend       (dllpend),
        .edb           (edb),
        .packetValid   (packetValid),
        .framing_error (framing_error)
`ifdef FRAME_ERR_CNT_EN
        ,
        .frame_err_cnt (frame_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [8*B-1:0] obs, input logic [8*B-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill();
        for (int i = 0; i < B; i++) rx_data[8*i +: 8] = 8'($urandom_range(0, 255));
        rx_kchar      = '0;
        rx_byte_valid = '1;
    endtask

    task automatic put(input int idx, input logic [7:0] val);
        rx_data[8*idx +: 8] = val;
        rx_kchar[idx]       = 1'b1;
    endtask

    // Push the expectation for the beat currently on the inputs, clock it, then compare.
    task automatic beat(input string tag,
                        input logic [B-1:0] ts, input logic [B-1:0] ds,
                        input logic [B-1:0] te, input logic [B-1:0] de,
                        input logic [B-1:0] eb, input logic [B-1:0] pv,
                        input logic err);
        exp_t e;
        e.data = (reset || !link_up) ? '0 : rx_data;
        e.ts = ts; e.ds = ds; e.te = te; e.de = de; e.eb = eb; e.pv = pv;
        e.err = err;
        e.rst = reset;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".data"}, packetData, e.data);
        chk({tag, ".tlpstart"}, tlpstart, e.ts);
        chk({tag, ".dllpstart"}, dllpstart, e.ds);
        chk({tag, ".tlpend"}, tlpend, e.te);
        chk({tag, ".dllpend"}, dllpend, e.de);
        chk({tag, ".edb"}, edb, e.eb);
        chk({tag, ".packetValid"}, packetValid, e.pv);
        chk({tag, ".framing_error"}, framing_error, e.err);
`ifdef FRAME_ERR_CNT_EN
        if (e.rst) exp_cnt = 0;
        else if (e.err) exp_cnt++;
        chk({tag, ".frame_err_cnt"}, frame_err_cnt, exp_cnt[15:0]);
`endif
    endtask

    initial begin
        reset   = 1'b1;
        link_up = 1'b1;
        gen     = 3'd2;
        fill(); put(63, 8'hFB);
        beat("reset", Z, Z, Z, Z, Z, Z, 1'b0);
        reset = 1'b0;

        gen = 3'd1; fill();
        beat("gen1_idle", Z, Z, Z, Z, Z, Z, 1'b0);

        gen = 3'd2; fill(); put(63, 8'hFB);
        beat("tlp_start", B63, Z, Z, Z, Z, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        fill(); put(0, 8'hFD);
        beat("tlp_end", Z, Z, 64'h1, Z, Z, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

        fill(); put(63, 8'h5C); put(56, 8'hFD);
        beat("dllp_ok", Z, B63, Z, 64'h0100_0000_0000_0000, Z, 64'h7E00_0000_0000_0000, 1'b0);
        fill(); put(63, 8'h5C); put(58, 8'hFD);
        beat("dllp_short", Z, B63, Z, 64'h0400_0000_0000_0000, Z, 64'h7800_0000_0000_0000, 1'b1);

        fill(); put(63, 8'hFB); put(60, 8'hFE);
        beat("tlp_edb", B63, Z, Z, Z, 64'h1000_0000_0000_0000, 64'h6000_0000_0000_0000, 1'b0);
        fill(); put(40, 8'hFD);
        beat("end_in_idle", Z, Z, Z, Z, Z, Z, 1'b1);

        fill(); put(0, 8'hFB);
        beat("start_byte0", 64'h1, Z, Z, Z, Z, Z, 1'b0);
        fill(); put(63, 8'hFD);
        beat("end_byte63", Z, Z, B63, Z, Z, Z, 1'b0);

        fill(); put(63, 8'hFB); put(20, 8'hFD);
        rx_byte_valid = 64'h8000_0000_0000_0400;
        beat("skip_invalid", B63, Z, Z, Z, Z, 64'h0000_0000_0000_0400, 1'b0);
        fill(); put(63, 8'hFD); put(61, 8'hFD);
        rx_byte_valid[63] = 1'b0;
        beat("skip_end", Z, Z, 64'h2000_0000_0000_0000, Z, Z, 64'h4000_0000_0000_0000, 1'b0);

        fill(); put(63, 8'h5C); put(55, 8'hFD);
        beat("dllp_long", Z, B63, Z, Z, Z, 64'h7F00_0000_0000_0000, 1'b1);
        fill(); put(63, 8'hFB); put(61, 8'h5C); put(54, 8'hFD);
        beat("restart", B63, 64'h2000_0000_0000_0000, Z, 64'h0040_0000_0000_0000, Z,
             64'h5F80_0000_0000_0000, 1'b1);

        fill(); put(0, 8'hFB);
        beat("open_tlp", 64'h1, Z, Z, Z, Z, Z, 1'b0);
        gen = 3'd3; fill(); put(63, 8'hFB); put(10, 8'hFD);
        rx_byte_valid = 64'hF0F0_FFFF_0000_FFFF;
        beat("bypass", Z, Z, Z, Z, Z, 64'hF0F0_FFFF_0000_FFFF, 1'b0);
        gen = 3'd2; fill(); put(63, 8'hFD);
        beat("after_bypass", Z, Z, Z, Z, Z, Z, 1'b1);

        fill(); put(63, 8'hFB);
        beat("pre_reset_tlp", B63, Z, Z, Z, Z, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        reset = 1'b1; fill(); put(63, 8'hFD);
        beat("reset_mid", Z, Z, Z, Z, Z, Z, 1'b0);
        reset = 1'b0; fill();
        beat("after_reset", Z, Z, Z, Z, Z, Z, 1'b0);

        fill(); put(63, 8'hFB);
        beat("open_tlp2", B63, Z, Z, Z, Z, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        link_up = 1'b0; fill(); put(62, 8'hFD);
        beat("link_down", Z, Z, Z, Z, Z, Z, 1'b0);
        link_up = 1'b1; fill();
        beat("after_link", Z, Z, Z, Z, Z, Z, 1'b0);

        reset = 1'b1; link_up = 1'b0; fill(); put(63, 8'hFB);
        beat("rst_and_down", Z, Z, Z, Z, Z, Z, 1'b0);
        reset = 1'b0; link_up = 1'b1; fill(); put(0, 8'hFD);
        beat("end_after_rst", Z, Z, Z, Z, Z, Z, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
